control_unit: RTL and testbench
===============================

# control_unit

Single-cycle control unit that drives every control input of the processor datapath from the fetched instruction word. It owns the architectural NZCV flag register, evaluates the ARM condition field, and gates all state-changing strobes on the result. It sits beside the datapath at the top level, taking `inst` and the ALU flags from the datapath and returning the full control bundle. It also keeps a sticky undefined-instruction indicator and optional performance counters.

## Interface
- No parameters.
- `clock  in  1` — sole clock; all state updates on rising edge.
- `rst  in  1` — asynchronous, active-low reset.
- `inst  in  32` — current instruction from instruction memory.
- `N`, `Z`, `CO`, `OVF`  in  1 each — combinational ALU flags for the current instruction.
- `PCSrc  out  1` — 1 selects `Result` as next PC.
- `RegSrc  out  2` — [0]: RA1 = 15; [1]: RA2 = `inst[15:12]`.
- `RegWrite`, `MemWrite`, `MemtoReg`, `ALUSrc`, `bx_mux`  out  1 each.
- `ImmSrc  out  2` — 00 imm8 zero-ext, 01 imm12 zero-ext, 10 imm24 sign-ext <<2.
- `shft_ctrl  out  2` — 00 LSL, 01 LSR, 10 ASR, 11 ROR.
- `shamt_ctrl  out  5`; `ALUControl  out  4`; `carry_in  out  1`.
- `mux_mine  out  2` — [0]: A3 = 14; [1]: WD3 = PC+4 (BL link).
- `flags  out  4` — registered {N,Z,C,V}.
- `undef  out  1` — sticky undefined-instruction flag.
- `retired_cnt`, `taken_cnt`, `condfail_cnt`  out  32 each — present only with `CTRL_PERF_CNT_EN`.

## Operation
- **Decode priority:**
  - BX (`inst[27:4]==24'h12FFF1`): `bx_mux`=1, `ALUSrc`=0, `ALUControl`=1101 (MOV), `shamt`=0, `PCSrc`=1. Target is always R14.
  - DP (`inst[27:26]==00`):
    - `ALUControl`=`inst[24:21]`; `ALUSrc`=`inst[25]`.
    - Immediate form: `ImmSrc`=00, `shft_ctrl`=11, `shamt_ctrl`={`inst[11:8]`,0}.
    - Register form: `shft_ctrl`=`inst[6:5]`, `shamt_ctrl`=`inst[11:7]`. `inst[4]`=1 is undefined.
    - `RegWrite`=1 except cmd 10xx (TST/TEQ/CMP/CMN), which require S=1; S=0 there is undefined.
  - MEM (`inst[27:26]==01`):
    - `ALUControl`=ADD if `inst[23]`, else SUB.
    - Immediate offset: `ALUSrc`=1, `ImmSrc`=01, `shamt`=0. Register offset (`inst[25]`=1): `ALUSrc`=0 with shift fields as DP.
    - LDR (`inst[20]`=1): `RegWrite`=1, `MemtoReg`=1.
    - STR: `MemWrite`=1, `RegSrc[1]`=1.
  - Branch (`inst[27:25]==101`): `RegSrc[0]`=1, `ALUSrc`=1, `ImmSrc`=10, `ALUControl`=0100, `PCSrc`=1. BL (`inst[24]`=1) also sets `RegWrite`=1, `mux_mine`=11.
  - `inst[27:26]==11` or cond=1111: undefined.
- **Write to PC:** any DP/LDR with Rd=15 and `RegWrite` also asserts `PCSrc`.
- **Condition evaluation:** `CondEx` computed from `inst[31:28]` against registered flags using standard EQ..AL semantics.
- **Gating:** `CondEx`=0 or undefined forces `RegWrite`, `MemWrite`, `PCSrc` and the flag write to 0. All other outputs remain decoded values.
- **Flag update** (`CondEx` and S or cmd 10xx):
  - Arithmetic cmds (ADD/ADC/SUB/SBC/RSB/RSC/CMP/CMN): N,Z,C,V ← `N`,`Z`,`CO`,`OVF`.
  - Logical cmds: N,Z only; C,V held.
- `carry_in` = registered C.
- **undef:** set on any decoded undefined instruction; cleared only by reset.

## Timing
- All control outputs are combinational from `inst` and registered state. Zero latency within the instruction's cycle.
- Flags, `undef` and counters update on the rising edge that retires the instruction. The next instruction sees the new flags.
- **Reset** (any time, including mid-program): flags=0000, `undef`=0, counters=0 immediately, asynchronously. Outputs then reflect `inst` with zero flags, so EQ fails and NE passes.
- First rising edge with `rst` high is the first retiring edge.

## Configuration
- `CTRL_PERF_CNT_EN` defined:
  - `retired_cnt` +1 every edge out of reset.
  - `taken_cnt` +1 when gated `PCSrc`=1.
  - `condfail_cnt` +1 when `CondEx`=0.
  - All wrap modulo 2^32; reset 0.
- Undefined: the three ports and their registers are absent. All other behaviour is identical.

## Test plan
- Reset low mid-run with flags=1111 → `flags`=0000 and `undef`=0 immediately. `BEQ` (0x0A000002) then gives `PCSrc`=0; `BNE` gives `PCSrc`=1.
- `SUBS R1,R1,R1` (0xE0511001) with N=0,Z=1,CO=1,OVF=0 → `RegWrite`=1, `ALUControl`=0010. Next cycle `flags`=0110; following `ADDEQ` has `RegWrite`=1.
- `ANDS` with Z=1, CO=0 after C=1 → `flags` Z=1, C still 1; `carry_in`=1.
- `BL` (0xEB000004) → `mux_mine`=11, `RegWrite`=1, `PCSrc`=1, `ImmSrc`=10, `RegSrc[0]`=1. `BX LR` (0xE12FFF1E) → `bx_mux`=1, `ALUControl`=1101, `PCSrc`=1.
- `STRNE R2,[R3,#8]` (0x15832008) with Z=1 → `MemWrite`=0, `condfail_cnt`+1. With Z=0 → `MemWrite`=1, `RegSrc`=10, `ImmSrc`=01, `ALUControl`=0100.
- `inst`=0xEC000000 → `undef`=1, all writes suppressed. `undef` stays 1 across subsequent valid instructions until reset.

Source files
------------

// File: rtl/control_unit.sv
// -----------------------------------------------------------------------------
// control_unit
//
// Single-cycle control unit for the ARM-subset datapath. It decodes the fetched
// instruction into the full datapath control bundle, holds the architectural
// NZCV flag register, evaluates the condition field against those flags and
// gates every state-changing strobe on the result. A sticky undefined-
// instruction indicator is kept. Optional performance counters are compiled
// in when the macro CTRL_PERF_CNT_EN is defined.
//
// Ports
//   clock          in   1   sole clock, rising edge
//   rst            in   1   asynchronous active-low reset
//   inst           in  32   current instruction word
//   N, Z, CO, OVF  in   1   combinational ALU flags for the current instruction
//   PCSrc          out  1   next PC = Result (gated)
//   RegSrc         out  2   [0] RA1 = 15, [1] RA2 = inst[15:12]
//   RegWrite       out  1   register file write (gated)
//   MemWrite       out  1   data memory write (gated)
//   MemtoReg       out  1   write-back from memory
//   ALUSrc         out  1   ALU operand B from extended immediate
//   bx_mux         out  1   BX target path select
//   ImmSrc         out  2   00 imm8, 01 imm12, 10 imm24 sign-ext << 2
//   shft_ctrl      out  2   00 LSL, 01 LSR, 10 ASR, 11 ROR
//   shamt_ctrl     out  5   shift amount
//   ALUControl     out  4   ALU command
//   carry_in       out  1   registered C flag
//   mux_mine       out  2   [0] A3 = 14, [1] WD3 = PC+4 (BL link)
//   flags          out  4   registered {N,Z,C,V}
//   undef          out  1   sticky undefined-instruction flag
//   retired_cnt    out 32   (CTRL_PERF_CNT_EN) edges retired out of reset
//   taken_cnt      out 32   (CTRL_PERF_CNT_EN) edges with gated PCSrc = 1
//   condfail_cnt   out 32   (CTRL_PERF_CNT_EN) edges with failed condition
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module control_unit (
   input  logic        clock,
   input  logic        rst,
   input  logic [31:0] inst,
   input  logic        N,
   input  logic        Z,
   input  logic        CO,
   input  logic        OVF,
   output logic        PCSrc,
   output logic [1:0]  RegSrc,
   output logic        RegWrite,
   output logic        MemWrite,
   output logic        MemtoReg,
   output logic        ALUSrc,
   output logic        bx_mux,
   output logic [1:0]  ImmSrc,
   output logic [1:0]  shft_ctrl,
   output logic [4:0]  shamt_ctrl,
   output logic [3:0]  ALUControl,
   output logic        carry_in,
   output logic [1:0]  mux_mine,
   output logic [3:0]  flags,
   output logic        undef
`ifdef CTRL_PERF_CNT_EN
   ,
   output logic [31:0] retired_cnt,
   output logic [31:0] taken_cnt,
   output logic [31:0] condfail_cnt
`endif
);

   // ---------------------------------------------------------------------
   // Instruction fields
   // ---------------------------------------------------------------------
   logic [3:0] cond;
   logic [1:0] op;
   logic [3:0] cmd;
   logic       s_bit;
   logic       rd_is_pc;
   logic       is_bx;

   assign cond     = inst[31:28];
   assign op       = inst[27:26];
   assign cmd      = inst[24:21];
   assign s_bit    = inst[20];
   assign rd_is_pc = (inst[15:12] == 4'hF);
   assign is_bx    = (inst[27:4] == 24'h12FFF1);

   // Rm of BX is fixed to R14 by the datapath, so the low nibble is never used.
   logic unused_inst;
   assign unused_inst = ^inst[3:0];

   // ---------------------------------------------------------------------
   // Architectural state
   // ---------------------------------------------------------------------
   logic [3:0] flags_q, flags_d;
   logic       undef_q, undef_d;

   logic flag_n, flag_z, flag_c, flag_v;
   assign flag_n = flags_q[3];
   assign flag_z = flags_q[2];
   assign flag_c = flags_q[1];
   assign flag_v = flags_q[0];

   // ---------------------------------------------------------------------
   // Decode (ungated)
   // ---------------------------------------------------------------------
   logic pc_src_dec;
   logic reg_write_dec;
   logic mem_write_dec;
   logic flag_wr_dec;
   logic undef_dec;

   always_comb begin
      RegSrc        = 2'b00;
      MemtoReg      = 1'b0;
      ALUSrc        = 1'b0;
      bx_mux        = 1'b0;
      ImmSrc        = 2'b00;
      shft_ctrl     = 2'b00;
      shamt_ctrl    = 5'd0;
      ALUControl    = 4'b0000;
      mux_mine      = 2'b00;
      pc_src_dec    = 1'b0;
      reg_write_dec = 1'b0;
      mem_write_dec = 1'b0;
      flag_wr_dec   = 1'b0;
      undef_dec     = 1'b0;

      // BX lives inside the DP encoding space, so it is matched first.
      if (is_bx) begin
         bx_mux     = 1'b1;
         ALUSrc     = 1'b0;
         ALUControl = 4'b1101;
         shamt_ctrl = 5'd0;
         pc_src_dec = 1'b1;
      end else begin
         case (op)
            2'b00: begin
               ALUControl = cmd;
               ALUSrc     = inst[25];
               if (inst[25]) begin
                  // Rotated immediate: imm8 ROR (2 * rot).
                  ImmSrc     = 2'b00;
                  shft_ctrl  = 2'b11;
                  shamt_ctrl = {inst[11:8], 1'b0};
               end else begin
                  shft_ctrl  = inst[6:5];
                  shamt_ctrl = inst[11:7];
                  // Register-specified shift amounts are not supported.
                  if (inst[4]) begin
                     undef_dec = 1'b1;
                  end
               end
               if (cmd[3:2] == 2'b10) begin
                  // TST/TEQ/CMP/CMN exist only as flag-setting forms.
                  if (!s_bit) begin
                     undef_dec = 1'b1;
                  end
               end else begin
                  reg_write_dec = 1'b1;
               end
               flag_wr_dec = s_bit | (cmd[3:2] == 2'b10);
               pc_src_dec  = reg_write_dec & rd_is_pc;
            end
            2'b01: begin
               ALUControl = inst[23] ? 4'b0100 : 4'b0010;
               if (inst[25]) begin
                  ALUSrc     = 1'b0;
                  shft_ctrl  = inst[6:5];
                  shamt_ctrl = inst[11:7];
               end else begin
                  ALUSrc     = 1'b1;
                  ImmSrc     = 2'b01;
                  shamt_ctrl = 5'd0;
               end
               if (inst[20]) begin
                  reg_write_dec = 1'b1;
                  MemtoReg      = 1'b1;
                  pc_src_dec    = rd_is_pc;
               end else begin
                  mem_write_dec = 1'b1;
                  RegSrc[1]     = 1'b1;
               end
            end
            2'b10: begin
               if (inst[25]) begin
                  RegSrc[0]  = 1'b1;
                  ALUSrc     = 1'b1;
                  ImmSrc     = 2'b10;
                  ALUControl = 4'b0100;
                  pc_src_dec = 1'b1;
                  if (inst[24]) begin
                     reg_write_dec = 1'b1;
                     mux_mine      = 2'b11;
                  end
               end
            end
            default: begin
               undef_dec = 1'b1;
            end
         endcase
      end

      if (cond == 4'hF) begin
         undef_dec = 1'b1;
      end
   end

   // ---------------------------------------------------------------------
   // Condition evaluation against the registered flags
   // ---------------------------------------------------------------------
   logic cond_ex;

   always_comb begin
      cond_ex = 1'b0;
      case (cond)
         4'h0: cond_ex = flag_z;
         4'h1: cond_ex = ~flag_z;
         4'h2: cond_ex = flag_c;
         4'h3: cond_ex = ~flag_c;
         4'h4: cond_ex = flag_n;
         4'h5: cond_ex = ~flag_n;
         4'h6: cond_ex = flag_v;
         4'h7: cond_ex = ~flag_v;
         4'h8: cond_ex = flag_c & ~flag_z;
         4'h9: cond_ex = ~flag_c | flag_z;
         4'hA: cond_ex = (flag_n == flag_v);
         4'hB: cond_ex = (flag_n != flag_v);
         4'hC: cond_ex = ~flag_z & (flag_n == flag_v);
         4'hD: cond_ex = flag_z | (flag_n != flag_v);
         // 1111 is rejected by decode; treating it as "passed" keeps it out
         // of the condition-fail statistics.
         default: cond_ex = 1'b1;
      endcase
   end

   // ---------------------------------------------------------------------
   // Gating of state-changing strobes
   // ---------------------------------------------------------------------
   logic exec_ok;
   logic flag_wr;

   assign exec_ok  = cond_ex & ~undef_dec;
   assign PCSrc    = pc_src_dec    & exec_ok;
   assign RegWrite = reg_write_dec & exec_ok;
   assign MemWrite = mem_write_dec & exec_ok;
   assign flag_wr  = flag_wr_dec   & exec_ok;

   // ---------------------------------------------------------------------
   // Flag next state: arithmetic commands load all four flags, logical
   // commands only N and Z (C and V are held).
   // ---------------------------------------------------------------------
   logic arith_cmd;

   always_comb begin
      arith_cmd = 1'b0;
      case (cmd)
         4'b0010, 4'b0011, 4'b0100, 4'b0101,
         4'b0110, 4'b0111, 4'b1010, 4'b1011: arith_cmd = 1'b1;
         default:                             arith_cmd = 1'b0;
      endcase
   end

   always_comb begin
      flags_d = flags_q;
      if (flag_wr) begin
         if (arith_cmd) begin
            flags_d = {N, Z, CO, OVF};
         end else begin
            flags_d = {N, Z, flags_q[1:0]};
         end
      end
   end

   assign undef_d = undef_q | undef_dec;

   always_ff @(posedge clock or negedge rst) begin
      if (!rst) begin
         flags_q <= 4'b0000;
         undef_q <= 1'b0;
      end else begin
         flags_q <= flags_d;
         undef_q <= undef_d;
      end
   end

   assign flags    = flags_q;
   assign carry_in = flags_q[1];
   assign undef    = undef_q;

`ifdef CTRL_PERF_CNT_EN
   // ---------------------------------------------------------------------
   // Performance counters (wrap modulo 2^32)
   // ---------------------------------------------------------------------
   logic [31:0] retired_cnt_q;
   logic [31:0] taken_cnt_q;
   logic [31:0] condfail_cnt_q;

   always_ff @(posedge clock or negedge rst) begin
      if (!rst) begin
         retired_cnt_q  <= 32'd0;
         taken_cnt_q    <= 32'd0;
         condfail_cnt_q <= 32'd0;
      end else begin
         retired_cnt_q <= retired_cnt_q + 32'd1;
         if (PCSrc) begin
            taken_cnt_q <= taken_cnt_q + 32'd1;
         end
         if (!cond_ex) begin
            condfail_cnt_q <= condfail_cnt_q + 32'd1;
         end
      end
   end

   assign retired_cnt  = retired_cnt_q;
   assign taken_cnt    = taken_cnt_q;
   assign condfail_cnt = condfail_cnt_q;
`endif

endmodule

// File: tb/tb_control_unit.sv
`timescale 1ns/1ps

module tb_control_unit;

   logic        clock;
   logic        rst;
   logic [31:0] inst;
   logic        n_in, z_in, co_in, ovf_in;
   logic        PCSrc;
   logic [1:0]  RegSrc;
   logic        RegWrite, MemWrite, MemtoReg, ALUSrc, bx_mux;
   logic [1:0]  ImmSrc, shft_ctrl, mux_mine;
   logic [4:0]  shamt_ctrl;
   logic [3:0]  ALUControl, flags;
   logic        carry_in, undef;
`ifdef CTRL_PERF_CNT_EN
   logic [31:0] retired_cnt, taken_cnt, condfail_cnt;
   logic [31:0] cf_before;
`endif

   int errors = 0;
   int checks = 0;

   control_unit dut (
      .clock      (clock),
      .rst        (rst),
      .inst       (inst),
      .N          (n_in),
      .Z          (z_in),
      .CO         (co_in),
      .OVF        (ovf_in),
      .PCSrc      (PCSrc),
      .RegSrc     (RegSrc),
      .RegWrite   (RegWrite),
      .MemWrite   (MemWrite),
      .MemtoReg   (MemtoReg),
      .ALUSrc     (ALUSrc),
      .bx_mux     (bx_mux),
      .ImmSrc     (ImmSrc),
      .shft_ctrl  (shft_ctrl),
      .shamt_ctrl (shamt_ctrl),
      .ALUControl (ALUControl),
      .carry_in   (carry_in),
      .mux_mine   (mux_mine),
      .flags      (flags),
      .undef      (undef)
`ifdef CTRL_PERF_CNT_EN
      ,
      .retired_cnt  (retired_cnt),
      .taken_cnt    (taken_cnt),
      .condfail_cnt (condfail_cnt)
`endif
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // Apply an instruction plus ALU flags and let the combinational outputs settle.
   task automatic drive(input logic [31:0] i, input logic [3:0] nzcv);
      inst = i;
      {n_in, z_in, co_in, ovf_in} = nzcv;
      #1;
      $display("inst=%08h alu_nzcv=%04b flags=%04b PCSrc=%0d RegWrite=%0d MemWrite=%0d undef=%0d",
               i, nzcv, flags, PCSrc, RegWrite, MemWrite, undef);
   endtask

   // Retire the current instruction; sample 1 ns after the edge.
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   initial begin
      rst  = 1'b0;
      inst = 32'hE1A00000;
      {n_in, z_in, co_in, ovf_in} = 4'b0000;
      #1;
      check("reset_flags", {28'd0, flags}, 32'h0);
      check("reset_undef", {31'd0, undef}, 32'h0);
      @(negedge clock);
      rst = 1'b1;

      // CMP R0,R0 loads all four flags
      drive(32'hE1500000, 4'b1111);
      check("cmp_regwrite", {31'd0, RegWrite}, 32'h0);
      check("cmp_aluctl", {28'd0, ALUControl}, 32'hA);
      tick();
      check("cmp_flags", {28'd0, flags}, 32'hF);

      // Asynchronous reset mid-run
      rst = 1'b0;
      #1;
      check("async_rst_flags", {28'd0, flags}, 32'h0);
      check("async_rst_undef", {31'd0, undef}, 32'h0);
      drive(32'h0A000002, 4'b0000);
      check("beq_after_rst", {31'd0, PCSrc}, 32'h0);
      drive(32'h1A000002, 4'b0000);
      check("bne_after_rst", {31'd0, PCSrc}, 32'h1);
      check("bne_immsrc", {30'd0, ImmSrc}, 32'h2);
      rst = 1'b1;

      // SUBS R1,R1,R1
      drive(32'hE0511001, 4'b0110);
      check("subs_regwrite", {31'd0, RegWrite}, 32'h1);
      check("subs_aluctl", {28'd0, ALUControl}, 32'h2);
      tick();
      check("subs_flags", {28'd0, flags}, 32'h6);

      // ADDEQ R0,R0,R0 : condition passes, S=0 so flags untouched
      drive(32'h00800000, 4'b1001);
      check("addeq_regwrite", {31'd0, RegWrite}, 32'h1);
      check("addeq_carry_in", {31'd0, carry_in}, 32'h1);
      tick();
      check("addeq_flags_held", {28'd0, flags}, 32'h6);

      // ANDS : logical, N/Z update only, C and V held
      drive(32'hE0100000, 4'b1101);
      tick();
      check("ands_flags", {28'd0, flags}, 32'hE);
      check("ands_carry_in", {31'd0, carry_in}, 32'h1);

      // BL
      drive(32'hEB000004, 4'b0000);
      check("bl_mux_mine", {30'd0, mux_mine}, 32'h3);
      check("bl_regwrite", {31'd0, RegWrite}, 32'h1);
      check("bl_pcsrc", {31'd0, PCSrc}, 32'h1);
      check("bl_immsrc", {30'd0, ImmSrc}, 32'h2);
      check("bl_regsrc", {30'd0, RegSrc}, 32'h1);
      check("bl_aluctl", {28'd0, ALUControl}, 32'h4);
      tick();

      // BX LR
      drive(32'hE12FFF1E, 4'b0101);
      check("bx_mux", {31'd0, bx_mux}, 32'h1);
      check("bx_aluctl", {28'd0, ALUControl}, 32'hD);
      check("bx_pcsrc", {31'd0, PCSrc}, 32'h1);
      check("bx_alusrc", {31'd0, ALUSrc}, 32'h0);
      check("bx_regwrite", {31'd0, RegWrite}, 32'h0);
      tick();
      check("bx_flags_held", {28'd0, flags}, 32'hE);

      // STRNE R2,[R3,#8] with Z=1 : condition fails
      drive(32'h15832008, 4'b0000);
      check("strne_fail_memwrite", {31'd0, MemWrite}, 32'h0);
      check("strne_fail_regsrc", {30'd0, RegSrc}, 32'h2);
`ifdef CTRL_PERF_CNT_EN
      cf_before = condfail_cnt;
`endif
      tick();
`ifdef CTRL_PERF_CNT_EN
      check("condfail_cnt_inc", condfail_cnt, cf_before + 32'd1);
`endif

      // MOVS R0,#imm rot=2 : clears Z
      drive(32'hE3B00201, 4'b0000);
      check("movs_alusrc", {31'd0, ALUSrc}, 32'h1);
      check("movs_immsrc", {30'd0, ImmSrc}, 32'h0);
      check("movs_shft", {30'd0, shft_ctrl}, 32'h3);
      check("movs_shamt", {27'd0, shamt_ctrl}, 32'h4);
      check("movs_regwrite", {31'd0, RegWrite}, 32'h1);
      tick();
      check("movs_flags", {28'd0, flags}, 32'h2);

      // STRNE with Z=0 : store happens
      drive(32'h15832008, 4'b0000);
      check("strne_memwrite", {31'd0, MemWrite}, 32'h1);
      check("strne_regsrc", {30'd0, RegSrc}, 32'h2);
      check("strne_immsrc", {30'd0, ImmSrc}, 32'h1);
      check("strne_aluctl", {28'd0, ALUControl}, 32'h4);
      check("strne_regwrite", {31'd0, RegWrite}, 32'h0);
      tick();

      // ADD R0,R1,R2,LSR #3
      drive(32'hE08101A2, 4'b0000);
      check("addreg_shft", {30'd0, shft_ctrl}, 32'h1);
      check("addreg_shamt", {27'd0, shamt_ctrl}, 32'h3);
      check("addreg_alusrc", {31'd0, ALUSrc}, 32'h0);
      check("addreg_pcsrc", {31'd0, PCSrc}, 32'h0);

      // MOV PC,LR : write to PC
      drive(32'hE1A0F00E, 4'b0000);
      check("movpc_pcsrc", {31'd0, PCSrc}, 32'h1);
      check("movpc_regwrite", {31'd0, RegWrite}, 32'h1);

      // LDR R0,[R1,#-4]
      drive(32'hE5110004, 4'b0000);
      check("ldr_regwrite", {31'd0, RegWrite}, 32'h1);
      check("ldr_memtoreg", {31'd0, MemtoReg}, 32'h1);
      check("ldr_aluctl", {28'd0, ALUControl}, 32'h2);
      check("ldr_immsrc", {30'd0, ImmSrc}, 32'h1);
      tick();

      // ADDS with register-specified shift : undefined, everything suppressed
      drive(32'hE0910112, 4'b1111);
      check("undef_dp_regwrite", {31'd0, RegWrite}, 32'h0);
      tick();
      check("undef_dp_sticky", {31'd0, undef}, 32'h1);
      check("undef_dp_flags_held", {28'd0, flags}, 32'h2);

      // Coprocessor space
      drive(32'hEC000000, 4'b0000);
      check("undef_ec_regwrite", {31'd0, RegWrite}, 32'h0);
      check("undef_ec_memwrite", {31'd0, MemWrite}, 32'h0);
      check("undef_ec_pcsrc", {31'd0, PCSrc}, 32'h0);
      tick();
      check("undef_ec_set", {31'd0, undef}, 32'h1);

      // Valid instruction afterwards : undef stays set
      drive(32'hE1A00000, 4'b0000);
      check("valid_after_undef_regwrite", {31'd0, RegWrite}, 32'h1);
      tick();
      check("undef_still_set", {31'd0, undef}, 32'h1);

      // Only reset clears it
      rst = 1'b0;
      #1;
      check("undef_cleared_by_rst", {31'd0, undef}, 32'h0);
      rst = 1'b1;

      // CMP with S=0 is undefined
      drive(32'hE1400000, 4'b1111);
      check("cmp_nos_regwrite", {31'd0, RegWrite}, 32'h0);
      tick();
      check("cmp_nos_undef", {31'd0, undef}, 32'h1);
      check("cmp_nos_flags", {28'd0, flags}, 32'h0);

      // cond = 1111 is undefined
      drive(32'hF0800000, 4'b0000);
      check("cond_nv_regwrite", {31'd0, RegWrite}, 32'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
